result_display_scheduler: RTL
=============================

# result_display_scheduler

Sequencer that owns the eight 6-bit segment codes feeding the board's seven-segment decoders during a blackjack round. It tracks the game FSM live while play is in progress, then freezes both hands and the result message for a fixed, visible hold time with an optional blink. It tells the game FSM when the hold has elapsed. It sits between the game FSM and the per-digit `sevenSegmentDecoder` instances.

## Interface
Parameters:
- PRESCALE, 25_000_000 — clock cycles per display tick (0.5 s at 50 MHz); must be ≥ 2
- HOLD_TICKS, 6 — ticks the latched result is held before `result_done`; must be ≥ 1
- BLINK_TICKS, 1 — ticks per visible/blank blink phase; must be ≥ 1

Ports:
- clk  in  1 — single system clock
- reset  in  1 — asynchronous, active-high; one clock, reset is asynchronous and active-high
- gameState  in  `gameState — current game FSM state
- playerHand  in  `hand (5) — player total, 0..31
- dealerHand  in  `hand (5) — dealer total, 0..31
- code7..code0  out  6 each — segment codes: code7/6 player tens/units, code5/4 dealer tens/units, code3..0 message
- busy  out  1 — high in RESULT_HOLD
- result_done  out  1 — one-cycle pulse at end of hold

## Operation
- States are TRACK, RESULT_HOLD and RESULT_DONE.
- TRACK:
  - Message follows gameState: S_RESET→STRT; S_DEAL_DEALER/S_DRAW_TO_17→DEAL; S_RESULT_WIN→" WIN"; S_RESULT_LOSE→LOSE; S_RESULT_TIE→" TIE"; otherwise PLAY. A blank digit is 6'h3F.
  - Hands pass through live.
- TRACK→RESULT_HOLD when gameState is sampled as a result state.
  - That same edge latches the result kind, playerHand and dealerHand.
  - The prescaler and tick counter clear on the same edge.
- RESULT_HOLD:
  - Shows the latched hands and message.
  - Later gameState changes between result states are ignored.
  - After HOLD_TICKS ticks, go to RESULT_DONE and pulse `result_done` for one cycle.
- RESULT_DONE:
  - Latched display held static and unblinking.
  - Returns to TRACK on the first cycle gameState is not a result state.
- Abort: gameState == S_RESET in RESULT_HOLD or RESULT_DONE → TRACK next edge, with no `result_done` pulse.
- Hand conversion for each 5-bit value v:
  - tens = v/10 (0..3), units = v mod 10.
  - Tens code is 6'h3F when v < 10 (leading-zero blank).
  - Comparison is done at 6-bit width.
- Prescaler is a free-running PRESCALE-cycle counter. `tick` is high for one cycle at terminal count and resets to 0 on the HOLD entry edge.

## Timing
- All outputs are registered. Output reflects inputs sampled one edge earlier (latency 1).
- Reset values:
  - code7..code0 = 6'h3F
  - busy = 0, result_done = 0
  - state = TRACK, prescaler = 0, tick counter = 0, blink phase = visible
- With HOLD entry sampled at edge E:
  - Ticks occur at E+PRESCALE, E+2·PRESCALE, …
  - `result_done` is high during the cycle following edge E+HOLD_TICKS·PRESCALE.
- `busy` is high from E+1 until `result_done` asserts, and low while `result_done` is high.
- Asynchronous reset mid-hold clears everything immediately. No `result_done` is emitted.

## Configuration
- RESULT_BLINK_EN defined:
  - In RESULT_HOLD, code3..code0 alternate between the message and 6'h3F every BLINK_TICKS ticks, starting visible.
  - Hand digits never blink.
  - Blink phase resets to visible on HOLD entry.
- RESULT_BLINK_EN undefined: the message is static during hold and there is no blink logic. BLINK_TICKS is unused.

## Structure
- Shared package `display_pkg`:
  - 6-bit segment code constants (digits, letters, OFF = 6'h3F) replacing the per-file defines
  - result kind enum {WIN, LOSE, TIE}
  - scheduler state enum
- Sub-module `tick_prescaler`:
  - parameter PRESCALE; ports clk, reset, clear, tick.
- Decimal split and message lookup are combinational functions in the package.

## Test plan
Benches use PRESCALE=4, HOLD_TICKS=3, BLINK_TICKS=1.
- Reset, then gameState=S_RESET, playerHand=0 → after 1 cycle code3..0 = S,T,R,T; code7=OFF, code6=0.
- TRACK, playerHand=21 then 7, dealerHand=19 → code7/6 = 2,1 then OFF,7; code5/4 = 1,9.
- gameState→S_RESULT_WIN with player 20, dealer 18; then hands change to 5/5 → display stays 2,0 / 1,8 / " WIN". `result_done` pulses exactly one cycle, 12 cycles after entry. `busy` is high for cycles 1–11.
- RESULT_BLINK_EN, LOSE entry → message visible until tick 1, OFF between ticks 1 and 2, visible after tick 2. Hands never blank.
- gameState→S_RESET 5 cycles into hold → TRACK next cycle, message STRT, no `result_done`. Re-entering TIE restarts the full 12-cycle hold.
- RESULT_DONE with gameState held at S_RESULT_TIE for 20 cycles → static " TIE", no further pulse. gameState→PLAY → live hands and PLAY message after 1 cycle.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: segment codes, game/result/scheduler enums and display helper functions
// Shared by result_display_scheduler and tick_prescaler; no ports.
package display_pkg;
  localparam logic [5:0] OFF = 6'h3F;
  localparam logic [5:0] C_A = 6'd10, C_D = 6'd13, C_E = 6'd14, C_I = 6'd18, C_L = 6'd21, C_N = 6'd23;
  localparam logic [5:0] C_O = 6'd24, C_P = 6'd25, C_R = 6'd27, C_S = 6'd28, C_T = 6'd29, C_W = 6'd32, C_Y = 6'd34;
  localparam logic [23:0] MSG_STRT = {C_S, C_T, C_R, C_T};
  localparam logic [23:0] MSG_DEAL = {C_D, C_E, C_A, C_L};
  localparam logic [23:0] MSG_WIN = {OFF, C_W, C_I, C_N};
  localparam logic [23:0] MSG_LOSE = {C_L, C_O, C_S, C_E};
  localparam logic [23:0] MSG_TIE = {OFF, C_T, C_I, C_E};
  localparam logic [23:0] MSG_PLAY = {C_P, C_L, C_A, C_Y};
  typedef enum logic [2:0] {
    S_RESET, S_DEAL_PLAYER, S_DEAL_DEALER, S_PLAYER_TURN,
    S_DRAW_TO_17, S_RESULT_WIN, S_RESULT_LOSE, S_RESULT_TIE
  } gameState_t;
  typedef enum logic [1:0] {WIN, LOSE, TIE} resultKind_t;
  typedef enum logic [1:0] {TRACK, RESULT_HOLD, RESULT_DONE} schedState_t;
  // {tens, units}; tens blanked below 10
  function automatic logic [11:0] splitHand(input logic [4:0] v);
    logic [5:0] w;
    w = {1'b0, v};
    return {w < 6'd10 ? OFF : w / 6'd10, w % 6'd10};
  endfunction
  function automatic logic isResult(input gameState_t g);
    return g == S_RESULT_WIN || g == S_RESULT_LOSE || g == S_RESULT_TIE;
  endfunction
  function automatic resultKind_t toKind(input gameState_t g);
    return g == S_RESULT_WIN ? WIN : g == S_RESULT_LOSE ? LOSE : TIE;
  endfunction
  function automatic logic [23:0] kindMsg(input resultKind_t k);
    return k == WIN ? MSG_WIN : k == LOSE ? MSG_LOSE : MSG_TIE;
  endfunction
  function automatic logic [23:0] stateMsg(input gameState_t g);
    return g == S_RESET ? MSG_STRT :
           (g == S_DEAL_DEALER || g == S_DRAW_TO_17) ? MSG_DEAL :
           isResult(g) ? kindMsg(toKind(g)) : MSG_PLAY;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running PRESCALE-cycle counter with one-cycle terminal-count tick
// Ports: clk, reset (async, active-high), clear (sync restart from 0), tick (high at terminal count).
import display_pkg::*;
module tick_prescaler #(
  parameter int PRESCALE = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(PRESCALE);
  logic [W-1:0] count;
  assign tick = count == W'(PRESCALE - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= (clear || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/result_display_scheduler.sv
// result_display_scheduler: drives eight segment codes, tracking play live and freezing the result for a timed hold
// Ports: clk, reset (async, active-high), gameState, playerHand/dealerHand (0..31),
//   code7/6 player tens/units, code5/4 dealer tens/units, code3..0 message, busy, result_done.
// Define RESULT_BLINK_EN to blink the message digits during the hold.
import display_pkg::*;
module result_display_scheduler #(
  parameter int PRESCALE = 25_000_000,
  parameter int HOLD_TICKS = 6,
  parameter int BLINK_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  gameState_t gameState,
  input  logic [4:0] playerHand,
  input  logic [4:0] dealerHand,
  output logic [5:0] code7,
  output logic [5:0] code6,
  output logic [5:0] code5,
  output logic [5:0] code4,
  output logic [5:0] code3,
  output logic [5:0] code2,
  output logic [5:0] code1,
  output logic [5:0] code0,
  output logic       busy,
  output logic       result_done
);
  localparam int TW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  schedState_t state, stNext;
  resultKind_t kind, kindNext;
  logic [4:0] pLat, dLat, pShow, dShow;
  logic [TW-1:0] tcnt, tcntNext;
  logic [23:0] msgNext;
  logic tick, enter, abort, holdEnd, showBlank;
  tick_prescaler #(.PRESCALE(PRESCALE)) prescaler (
    .clk(clk),
    .reset(reset),
    .clear(enter),
    .tick(tick)
  );
  always_comb begin
    enter = state == TRACK && isResult(gameState);
    abort = state != TRACK && gameState == S_RESET;
    holdEnd = state == RESULT_HOLD && tick && tcnt == TW'(HOLD_TICKS - 1);
    stNext = abort ? TRACK :
             state == TRACK ? (enter ? RESULT_HOLD : TRACK) :
             state == RESULT_HOLD ? (holdEnd ? RESULT_DONE : RESULT_HOLD) :
             isResult(gameState) ? RESULT_DONE : TRACK;
    // latches simply follow the live inputs while tracking, so entry captures them for free
    pShow = (state == TRACK || stNext == TRACK) ? playerHand : pLat;
    dShow = (state == TRACK || stNext == TRACK) ? dealerHand : dLat;
    kindNext = state == TRACK ? toKind(gameState) : kind;
    tcntNext = enter ? '0 : (state == RESULT_HOLD && tick) ? tcnt + 1'b1 : tcnt;
    msgNext = stNext == TRACK ? stateMsg(gameState) : kindMsg(kindNext);
  end
`ifdef RESULT_BLINK_EN
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  logic [BW-1:0] bcnt, bcntNext;
  logic blank, blankNext, phaseEnd;
  always_comb begin
    phaseEnd = state == RESULT_HOLD && tick && bcnt == BW'(BLINK_TICKS - 1);
    bcntNext = (enter || phaseEnd) ? '0 : (state == RESULT_HOLD && tick) ? bcnt + 1'b1 : bcnt;
    blankNext = enter ? 1'b0 : phaseEnd ? ~blank : blank;
    showBlank = blankNext && stNext == RESULT_HOLD;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bcnt <= '0;
      blank <= 1'b0;
    end else begin
      bcnt <= bcntNext;
      blank <= blankNext;
    end
`else
  assign showBlank = 1'b0;
  // BLINK_TICKS only matters with blinking; here its legal range is the sole reference
  if (BLINK_TICKS < 1) begin : g_blinkTicksInvalid
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= TRACK;
      kind <= WIN;
      pLat <= '0;
      dLat <= '0;
      tcnt <= '0;
      busy <= 1'b0;
      result_done <= 1'b0;
      {code7, code6, code5, code4, code3, code2, code1, code0} <= {8{OFF}};
    end else begin
      state <= stNext;
      kind <= kindNext;
      pLat <= pShow;
      dLat <= dShow;
      tcnt <= tcntNext;
      busy <= state == RESULT_HOLD && stNext == RESULT_HOLD;
      result_done <= holdEnd && !abort;
      {code7, code6, code5, code4} <= {splitHand(pShow), splitHand(dShow)};
      {code3, code2, code1, code0} <= showBlank ? {4{OFF}} : msgNext;
    end
endmodule
